// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage MIPS core hazard logic: widths, Tuse/Tnew
// encoding, MDU state encoding and default MDU latencies.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int TW   = 2;

  localparam logic [TW-1:0] TUSE_NONE = '1;

  localparam int DEF_MULT_CYC = 5;
  localparam int DEF_DIV_CYC  = 10;

  typedef enum logic {
    MDU_IDLE,
    MDU_BUSY
  } mdu_state_e;

  // Register $0 is hard-wired, so it never takes part in a dependency.
  function automatic logic reg_hit(input logic [AW-1:0] src, input logic [AW-1:0] dst);
    return (src != '0) && (src == dst);
  endfunction

endpackage

// File: rtl/mdu_busy_tracker.sv
// Tracks how long the multi-cycle mult/div unit stays occupied after it starts in E.
// busy is asserted in the start cycle and for exactly N-1 further cycles.
module mdu_busy_tracker
  import cpu_pkg::*;
#(
  parameter int MULT_CYC = DEF_MULT_CYC,
  parameter int DIV_CYC  = DEF_DIV_CYC
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  localparam int CW = $clog2(DIV_CYC + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYC - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYC - 1);

  mdu_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] load;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt holds the busy cycles left including the current one, so the unit
  // frees up when the count would run out, keeping the total at exactly N.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = is_div ? DIV_LOAD : MULT_LOAD;
    case (state_q)
      MDU_IDLE: begin
        if (start && (load != '0)) begin
          state_d = MDU_BUSY;
          cnt_d   = load;
        end
      end
      MDU_BUSY: begin
        if (cnt_q > CW'(1)) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = MDU_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = MDU_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy = (state_q == MDU_BUSY) | start;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: Tuse/Tnew stalls, E/M/W/post-W forwarding and MDU busy stalls.
// Optional HAZARD_STATS_EN adds saturating stall_cnt and mdu_stall_cnt outputs.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int MULT_CYC = DEF_MULT_CYC,
  parameter int DIV_CYC  = DEF_DIV_CYC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   rs_a_D,
  input  logic [AW-1:0]   rt_a_D,
  input  logic [XLEN-1:0] rs_v_D,
  input  logic [XLEN-1:0] rt_v_D,
  input  logic [TW-1:0]   rs_tuse_D,
  input  logic [TW-1:0]   rt_tuse_D,
  input  logic [AW-1:0]   rs_a_E,
  input  logic [AW-1:0]   rt_a_E,
  input  logic [XLEN-1:0] rs_v_E,
  input  logic [XLEN-1:0] rt_v_E,
  input  logic [AW-1:0]   rt_a_M,
  input  logic [XLEN-1:0] rt_v_M,
  input  logic [AW-1:0]   wa_E,
  input  logic [AW-1:0]   wa_M,
  input  logic [AW-1:0]   wa_W,
  input  logic [XLEN-1:0] wv_E,
  input  logic [XLEN-1:0] wv_M,
  input  logic [XLEN-1:0] wv_W,
  input  logic [TW-1:0]   tnew_E,
  input  logic [TW-1:0]   tnew_M,
  input  logic            mdu_start_E,
  input  logic            mdu_div_E,
  input  logic            mdu_use_D,
  output logic            stall_F,
  output logic            stall_D,
  output logic            flush_E,
  output logic [XLEN-1:0] fwd_rs_D,
  output logic [XLEN-1:0] fwd_rt_D,
  output logic [XLEN-1:0] fwd_rs_E,
  output logic [XLEN-1:0] fwd_rt_E,
  output logic [XLEN-1:0] fwd_rt_M,
  output logic            mdu_busy
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     mdu_stall_cnt
`endif
);

  logic [AW-1:0]   wa_H;
  logic [XLEN-1:0] wv_H;
  logic            data_stall;
  logic            mdu_stall;
  logic            stall;

  mdu_busy_tracker #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC)
  ) u_mdu (
    .clk    (clk),
    .reset  (reset),
    .start  (mdu_start_E),
    .is_div (mdu_div_E),
    .busy   (mdu_busy)
  );

  // A match in E shadows any older match in M for the same source.
  function automatic logic src_stall(input logic [AW-1:0] src, input logic [TW-1:0] tuse);
    if (reg_hit(src, wa_E)) return tuse < tnew_E;
    if (reg_hit(src, wa_M)) return tuse < tnew_M;
    return 1'b0;
  endfunction

  function automatic logic [XLEN-1:0] fwd_d(input logic [AW-1:0] src, input logic [XLEN-1:0] rf);
    if (reg_hit(src, wa_E) && (tnew_E == '0)) return wv_E;
    if (reg_hit(src, wa_M) && (tnew_M == '0)) return wv_M;
    return rf;
  endfunction

  // The post-W hold covers a regfile write and read landing on the same edge.
  function automatic logic [XLEN-1:0] fwd_wh(input logic [AW-1:0] src, input logic [XLEN-1:0] pipe);
    if (reg_hit(src, wa_W)) return wv_W;
    if (reg_hit(src, wa_H)) return wv_H;
    return pipe;
  endfunction

  function automatic logic [XLEN-1:0] fwd_e(input logic [AW-1:0] src, input logic [XLEN-1:0] pipe);
    if (reg_hit(src, wa_M) && (tnew_M == '0)) return wv_M;
    return fwd_wh(src, pipe);
  endfunction

  always_comb begin
    data_stall = src_stall(rs_a_D, rs_tuse_D) | src_stall(rt_a_D, rt_tuse_D);
    mdu_stall  = mdu_use_D & mdu_busy;
    stall      = data_stall | mdu_stall;
    stall_F    = stall;
    stall_D    = stall;
    flush_E    = stall;
    fwd_rs_D   = fwd_d(rs_a_D, rs_v_D);
    fwd_rt_D   = fwd_d(rt_a_D, rt_v_D);
    fwd_rs_E   = fwd_e(rs_a_E, rs_v_E);
    fwd_rt_E   = fwd_e(rt_a_E, rt_v_E);
    fwd_rt_M   = fwd_wh(rt_a_M, rt_v_M);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wa_H <= '0;
      wv_H <= '0;
    end else begin
      wa_H <= wa_W;
      wv_H <= wv_W;
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt     <= '0;
      mdu_stall_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1))         stall_cnt     <= stall_cnt + 32'd1;
      if (mdu_stall && (mdu_stall_cnt != '1)) mdu_stall_cnt <= mdu_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: stalls, forwarding priority, MDU busy timing,
// reset behaviour and (with HAZARD_STATS_EN) the saturating statistics counters.
module tb_hazard_ctrl;
  import cpu_pkg::*;

  logic            clk;
  logic            reset;
  logic [AW-1:0]   rs_a_D, rt_a_D, rs_a_E, rt_a_E, rt_a_M, wa_E, wa_M, wa_W;
  logic [XLEN-1:0] rs_v_D, rt_v_D, rs_v_E, rt_v_E, rt_v_M, wv_E, wv_M, wv_W;
  logic [TW-1:0]   rs_tuse_D, rt_tuse_D, tnew_E, tnew_M;
  logic            mdu_start_E, mdu_div_E, mdu_use_D;
  logic            stall_F, stall_D, flush_E, mdu_busy;
  logic [XLEN-1:0] fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M;
`ifdef HAZARD_STATS_EN
  logic [31:0]     stall_cnt, mdu_stall_cnt;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  hazard_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .rs_a_D      (rs_a_D),
    .rt_a_D      (rt_a_D),
    .rs_v_D      (rs_v_D),
    .rt_v_D      (rt_v_D),
    .rs_tuse_D   (rs_tuse_D),
    .rt_tuse_D   (rt_tuse_D),
    .rs_a_E      (rs_a_E),
    .rt_a_E      (rt_a_E),
    .rs_v_E      (rs_v_E),
    .rt_v_E      (rt_v_E),
    .rt_a_M      (rt_a_M),
    .rt_v_M      (rt_v_M),
    .wa_E        (wa_E),
    .wa_M        (wa_M),
    .wa_W        (wa_W),
    .wv_E        (wv_E),
    .wv_M        (wv_M),
    .wv_W        (wv_W),
    .tnew_E      (tnew_E),
    .tnew_M      (tnew_M),
    .mdu_start_E (mdu_start_E),
    .mdu_div_E   (mdu_div_E),
    .mdu_use_D   (mdu_use_D),
    .stall_F     (stall_F),
    .stall_D     (stall_D),
    .flush_E     (flush_E),
    .fwd_rs_D    (fwd_rs_D),
    .fwd_rt_D    (fwd_rt_D),
    .fwd_rs_E    (fwd_rs_E),
    .fwd_rt_E    (fwd_rt_E),
    .fwd_rt_M    (fwd_rt_M),
    .mdu_busy    (mdu_busy)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cnt     (stall_cnt),
    .mdu_stall_cnt (mdu_stall_cnt)
`endif
  );

  // Clock/reset: inputs change 1ns after a rising edge, outputs are checked 1ns later.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    reset = 1'b1;
    rs_a_D = '0; rt_a_D = '0; rs_a_E = '0; rt_a_E = '0; rt_a_M = '0;
    wa_E = '0; wa_M = '0; wa_W = '0;
    rs_v_D = 32'h0000_D0D0; rt_v_D = 32'h0000_D1D1;
    rs_v_E = 32'h0000_E0E0; rt_v_E = 32'h0000_E1E1; rt_v_M = 32'h0000_F0F0;
    wv_E = '0; wv_M = '0; wv_W = '0;
    rs_tuse_D = TUSE_NONE; rt_tuse_D = TUSE_NONE; tnew_E = '0; tnew_M = '0;
    mdu_start_E = 1'b0; mdu_div_E = 1'b0; mdu_use_D = 1'b0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    mdu_start_E = 1'b1;
    #1;
    total_cnt++; if (mdu_busy !== 1'b1) $display("FAIL rst_busy_follows_start: got %b exp 1", mdu_busy); else pass_cnt++;
    step();
    step();
    mdu_start_E = 1'b0;
    #1;
    total_cnt++; if (mdu_busy !== 1'b0) $display("FAIL rst_busy_idle: got %b exp 0", mdu_busy); else pass_cnt++;
    reset = 1'b1;
    step();
    total_cnt++; if ({stall_F, stall_D, flush_E} !== 3'b000) $display("FAIL rst_stall: got %b exp 000", {stall_F, stall_D, flush_E}); else pass_cnt++;
    total_cnt++; if (fwd_rs_D !== 32'h0000_D0D0) $display("FAIL rst_fwd_rs_D: got %h exp 0000d0d0", fwd_rs_D); else pass_cnt++;
    total_cnt++; if (fwd_rt_M !== 32'h0000_F0F0) $display("FAIL rst_fwd_rt_M: got %h exp 0000f0f0", fwd_rt_M); else pass_cnt++;
  endtask

  task automatic test_load_use();
    clear_inputs();
    wa_E = 5'd1; tnew_E = 2'd2; rs_a_D = 5'd1; rs_tuse_D = 2'd0;
    #1;
    total_cnt++; if ({stall_F, stall_D, flush_E} !== 3'b111) $display("FAIL lu_E_stall: got %b exp 111", {stall_F, stall_D, flush_E}); else pass_cnt++;
    step();
    wa_E = '0; tnew_E = '0; wa_M = 5'd1; tnew_M = 2'd1; wv_M = 32'h0000_0BAD;
    #1;
    total_cnt++; if ({stall_F, stall_D, flush_E} !== 3'b111) $display("FAIL lu_M_stall: got %b exp 111", {stall_F, stall_D, flush_E}); else pass_cnt++;
    rs_tuse_D = 2'd1;
    #1;
    total_cnt++; if (stall_F !== 1'b0) $display("FAIL lu_tuse_eq_tnew: got %b exp 0", stall_F); else pass_cnt++;
    rs_tuse_D = 2'd0;
    step();
    tnew_M = 2'd0; wv_M = 32'h0000_CAFE; rs_v_D = 32'h0000_1111;
    #1;
    total_cnt++; if (stall_D !== 1'b0) $display("FAIL lu_ready_nostall: got %b exp 0", stall_D); else pass_cnt++;
    total_cnt++; if (fwd_rs_D !== 32'h0000_CAFE) $display("FAIL lu_fwd_M: got %h exp 0000cafe", fwd_rs_D); else pass_cnt++;
    clear_inputs();
    wa_E = 5'd7; tnew_E = 2'd3; rt_a_D = 5'd7; rt_tuse_D = TUSE_NONE;
    #1;
    total_cnt++; if (flush_E !== 1'b0) $display("FAIL lu_tuse_none: got %b exp 0", flush_E); else pass_cnt++;
    wa_E = '0; rt_a_D = '0; rt_tuse_D = 2'd0;
    #1;
    total_cnt++; if (flush_E !== 1'b0) $display("FAIL lu_reg0: got %b exp 0", flush_E); else pass_cnt++;
    rt_a_D = 5'd7; rs_a_D = 5'd9; wa_E = 5'd9; tnew_E = 2'd1; wa_M = 5'd7; tnew_M = 2'd1;
    #1;
    total_cnt++; if (stall_F !== 1'b1) $display("FAIL lu_rt_M_stall: got %b exp 1", stall_F); else pass_cnt++;
  endtask

  task automatic test_fwd_priority();
    clear_inputs();
    wa_E = 5'd3; wa_M = 5'd3; tnew_E = 2'd0; tnew_M = 2'd0;
    wv_E = 32'h0000_AAAA; wv_M = 32'h0000_5555; rs_a_D = 5'd3; rs_tuse_D = 2'd0;
    #1;
    total_cnt++; if (fwd_rs_D !== 32'h0000_AAAA) $display("FAIL fp_E_over_M: got %h exp 0000aaaa", fwd_rs_D); else pass_cnt++;
    total_cnt++; if (stall_F !== 1'b0) $display("FAIL fp_nostall: got %b exp 0", stall_F); else pass_cnt++;
    rs_a_D = '0; rs_v_D = 32'h1357_9BDF;
    #1;
    total_cnt++; if (fwd_rs_D !== 32'h1357_9BDF) $display("FAIL fp_reg0_pass: got %h exp 13579bdf", fwd_rs_D); else pass_cnt++;
    tnew_E = 2'd1; rt_a_D = 5'd3; rt_tuse_D = 2'd2;
    #1;
    total_cnt++; if (fwd_rt_D !== 32'h0000_5555) $display("FAIL fp_M_when_E_notready: got %h exp 00005555", fwd_rt_D); else pass_cnt++;
  endtask

  task automatic test_mdu();
    logic exp;
    clear_inputs();
    mdu_use_D = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      mdu_start_E = (c == 0); mdu_div_E = 1'b1;
      #1;
      exp = (c < 10);
      total_cnt++; if (stall_F !== exp) $display("FAIL mdu_div_stall c%0d: got %b exp %b", c, stall_F, exp); else pass_cnt++;
      step();
    end
    clear_inputs();
    mdu_use_D = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      mdu_start_E = (c == 0); mdu_div_E = 1'b0;
      #1;
      exp = (c < 5);
      total_cnt++; if (mdu_busy !== exp) $display("FAIL mdu_mult_busy c%0d: got %b exp %b", c, mdu_busy, exp); else pass_cnt++;
      step();
    end
    clear_inputs();
    for (int c = 0; c <= 10; c++) begin
      mdu_start_E = (c == 0) || (c == 3); mdu_div_E = (c == 0);
      #1;
      exp = (c < 10);
      total_cnt++; if (mdu_busy !== exp) $display("FAIL mdu_restart_ignored c%0d: got %b exp %b", c, mdu_busy, exp); else pass_cnt++;
      step();
    end
  endtask

  task automatic test_post_w();
    clear_inputs();
    wa_W = 5'd5; wv_W = 32'h0000_1234;
    step();
    wa_W = '0; wv_W = '0; rs_a_E = 5'd5; rs_v_E = 32'hDEAD_0000;
    rt_a_M = 5'd5;
    #1;
    total_cnt++; if (fwd_rs_E !== 32'h0000_1234) $display("FAIL pw_hold_E: got %h exp 00001234", fwd_rs_E); else pass_cnt++;
    total_cnt++; if (fwd_rt_M !== 32'h0000_1234) $display("FAIL pw_hold_M: got %h exp 00001234", fwd_rt_M); else pass_cnt++;
    wa_W = 5'd5; wv_W = 32'h0000_7777;
    #1;
    total_cnt++; if (fwd_rt_M !== 32'h0000_7777) $display("FAIL pw_W_over_hold: got %h exp 00007777", fwd_rt_M); else pass_cnt++;
    wa_M = 5'd5; tnew_M = 2'd0; wv_M = 32'h0000_9999;
    #1;
    total_cnt++; if (fwd_rs_E !== 32'h0000_9999) $display("FAIL pw_M_over_W: got %h exp 00009999", fwd_rs_E); else pass_cnt++;
    tnew_M = 2'd1; rt_a_E = 5'd5; rt_v_E = 32'h0000_0001;
    #1;
    total_cnt++; if (fwd_rt_E !== 32'h0000_7777) $display("FAIL pw_W_when_M_notready: got %h exp 00007777", fwd_rt_E); else pass_cnt++;
    step();
    step();
    clear_inputs();
    rs_a_E = 5'd6;
    #1;
    total_cnt++; if (fwd_rs_E !== 32'h0000_E0E0) $display("FAIL pw_pipe_pass: got %h exp 0000e0e0", fwd_rs_E); else pass_cnt++;
  endtask

  task automatic test_reset_busy();
    clear_inputs();
    mdu_start_E = 1'b1; mdu_div_E = 1'b1;
    step();
    mdu_start_E = 1'b0;
    step(); step(); step();
    total_cnt++; if (mdu_busy !== 1'b1) $display("FAIL rb_busy_before: got %b exp 1", mdu_busy); else pass_cnt++;
    reset = 1'b0;
    step();
    reset = 1'b1; mdu_use_D = 1'b1;
    #1;
    total_cnt++; if (mdu_busy !== 1'b0) $display("FAIL rb_busy_after: got %b exp 0", mdu_busy); else pass_cnt++;
    total_cnt++; if (stall_D !== 1'b0) $display("FAIL rb_stall_after: got %b exp 0", stall_D); else pass_cnt++;
`ifdef HAZARD_STATS_EN
    total_cnt++; if (stall_cnt !== 32'd0) $display("FAIL rb_stall_cnt: got %0d exp 0", stall_cnt); else pass_cnt++;
    total_cnt++; if (mdu_stall_cnt !== 32'd0) $display("FAIL rb_mdu_stall_cnt: got %0d exp 0", mdu_stall_cnt); else pass_cnt++;
`endif
  endtask

`ifdef HAZARD_STATS_EN
  task automatic test_stats();
    apply_reset();
    mdu_use_D = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      mdu_start_E = (c == 0); mdu_div_E = 1'b1;
      step();
    end
    mdu_use_D = 1'b0;
    #1;
    total_cnt++; if (stall_cnt !== 32'd10) $display("FAIL st_stall_cnt: got %0d exp 10", stall_cnt); else pass_cnt++;
    total_cnt++; if (mdu_stall_cnt !== 32'd10) $display("FAIL st_mdu_stall_cnt: got %0d exp 10", mdu_stall_cnt); else pass_cnt++;
    wa_E = 5'd2; tnew_E = 2'd2; rs_a_D = 5'd2; rs_tuse_D = 2'd0;
    step();
    total_cnt++; if (stall_cnt !== 32'd11) $display("FAIL st_data_stall_cnt: got %0d exp 11", stall_cnt); else pass_cnt++;
    total_cnt++; if (mdu_stall_cnt !== 32'd10) $display("FAIL st_mdu_unchanged: got %0d exp 10", mdu_stall_cnt); else pass_cnt++;
    force dut.stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt;
    step();
    step();
    total_cnt++; if (stall_cnt !== 32'hFFFF_FFFF) $display("FAIL st_saturate: got %h exp ffffffff", stall_cnt); else pass_cnt++;
    clear_inputs();
  endtask
`endif

  initial begin
    clear_inputs();
    test_reset();
    test_load_use();
    test_fwd_priority();
    test_mdu();
    test_post_w();
    test_reset_busy();
`ifdef HAZARD_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
